// File: rtl/spi_fram_pkg.sv
// Shared opcodes, FSM state encoding and default RAM address width for the SPI FRAM target.
package spi_fram_pkg;

    localparam int ADDR_W_DEFAULT = 13;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus rise/fall detection on the synchronized value.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_fram_target.sv
// SPI mode-0 target emulating a FRAM (READ 0x03 / WRITE 0x02) in front of a local synchronous RAM.
// Optional write-enable latch (WREN 0x06 / WRDI 0x04) built when SPI_FRAM_TARGET_WREN_EN is defined.
module spi_fram_target
    import spi_fram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              active,
    output state_e            dbg_state
);

    logic ss_s, ss_rise, ss_fall;
    logic sck_rise, sck_fall, unused_sck_s;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .din(ss), .sync(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .reset(reset), .din(sck), .sync(unused_sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi), .sync(mosi_s),
        .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-2:0] shift_q, shift_d;
    logic [6:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              pend_q, pend_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_in;
    logic              wr_ok;

`ifdef SPI_FRAM_TARGET_WREN_EN
    logic wel_q, wel_d;
    assign wr_ok = wel_q;
`else
    assign wr_ok = 1'b1;
`endif

    // Incoming bit completes the byte/address in the same cycle it is sampled.
    assign byte_in = {shift_q[6:0], mosi_s};
    assign addr_in = {shift_q, mosi_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        pend_d     = 1'b0;
        cmd_rd_d   = cmd_rd_q;
`ifdef SPI_FRAM_TARGET_WREN_EN
        wel_d      = wel_q;
`endif
        if (ss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
`ifdef SPI_FRAM_TARGET_WREN_EN
            if (state_q == ST_WRITE || (state_q == ST_ADDR && !cmd_rd_q)) begin
                wel_d = 1'b0;
            end
`endif
        end else begin
            pend_d = re_q;
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[ADDR_W-3:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            case (byte_in)
                                OP_READ: begin
                                    state_d  = ST_ADDR;
                                    cmd_rd_d = 1'b1;
                                end
                                OP_WRITE: begin
                                    state_d  = ST_ADDR;
                                    cmd_rd_d = 1'b0;
                                end
`ifdef SPI_FRAM_TARGET_WREN_EN
                                OP_WREN: begin
                                    state_d = ST_IGNORE;
                                    wel_d   = 1'b1;
                                end
                                OP_WRDI: begin
                                    state_d = ST_IGNORE;
                                    wel_d   = 1'b0;
                                end
`endif
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[ADDR_W-3:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_d = '0;
                            if (cmd_rd_q) begin
                                mem_addr_d = addr_in;
                                addr_d     = addr_in + ADDR_W'(1);
                                re_d       = 1'b1;
                                state_d    = ST_READ;
                            end else begin
                                addr_d  = addr_in;
                                state_d = ST_WRITE;
                            end
                        end
                    end
                end
                ST_READ: begin
                    // The fall right after a byte boundary keeps the preloaded MSB on miso.
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d  = '0;
                            mem_addr_d = addr_q;
                            addr_d     = addr_q + ADDR_W'(1);
                            re_d       = 1'b1;
                        end
                    end else if (sck_fall && bit_cnt_q != 4'd0) begin
                        miso_d = tx_q[6];
                        tx_d   = {tx_q[5:0], 1'b0};
                    end
                    if (pend_q) begin
                        miso_d = mem_rdata[7];
                        tx_d   = mem_rdata[6:0];
                    end
                end
                ST_WRITE: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[ADDR_W-3:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d  = '0;
                            mem_addr_d = addr_q;
                            wdata_d    = byte_in;
                            we_d       = wr_ok;
                            addr_d     = addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            pend_q     <= 1'b0;
            cmd_rd_q   <= 1'b0;
`ifdef SPI_FRAM_TARGET_WREN_EN
            wel_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            pend_q     <= pend_d;
            cmd_rd_q   <= cmd_rd_d;
`ifdef SPI_FRAM_TARGET_WREN_EN
            wel_q      <= wel_d;
`endif
        end
    end

    assign miso      = miso_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign active    = ~ss_s;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_fram_target.sv
// Bench for spi_fram_target: random SPI transactions against a transaction-level FRAM model.
module tb_spi_fram_target;
    import spi_fram_pkg::*;

    localparam int AW     = 13;
    localparam int MEM_SZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ss = 1'b1;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_we;
    logic          mem_re;
    logic          active;
    state_e        dbg_state;

    always #5 clk = ~clk;

    spi_fram_target #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .active(active), .dbg_state(dbg_state)
    );

    logic [7:0]      ram[MEM_SZ];
    logic [7:0]      ref_mem[MEM_SZ];
    logic [AW+7:0]   obs_q[$];
    logic [AW+7:0]   exp_q[$];
    int              re_cnt = 0;
    int              miso_hi = 0;
    int              both_hi = 0;
    int              n_vec = 0;
    int              n_err = 0;
    int              obs_rd = 0;
    int              half = 5;
    bit              wel_m = 1'b0;

    // RAM environment: read data valid the cycle after mem_re; strobes logged.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            obs_q.push_back({mem_addr, mem_wdata});
        end
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
            re_cnt++;
        end
        if (miso) miso_hi++;
        if (mem_we && mem_re) both_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(half);
            sck = 1'b1;
            rx  = {rx[6:0], miso};
            tick(half);
            sck = 1'b0;
        end
    endtask

    // cut_bits < 0: all data bytes complete; otherwise ss rises after cut_bits bits of the last byte.
    task automatic run_txn(input logic [7:0] op, input logic [15:0] addr, input int nbytes,
                           input int cut_bits);
        logic [7:0]    rx, data;
        logic [AW-1:0] a;
        logic [AW+7:0] e;
        int            kind, re0, mh0, obs0, nb;
        bit            wr_ok_m;
        half = $urandom_range(4, 7);
        re0  = re_cnt;
        mh0  = miso_hi;
        obs0 = obs_q.size();
        kind = (op == OP_READ) ? 1 : (op == OP_WRITE) ? 2 : 0;
`ifdef SPI_FRAM_TARGET_WREN_EN
        if (op == OP_WREN) wel_m = 1'b1;
        if (op == OP_WRDI) wel_m = 1'b0;
        wr_ok_m = wel_m;
`else
        wr_ok_m = 1'b1;
`endif
        a = addr[AW-1:0];
        ss = 1'b0;
        tick(half);
        spi_bits(op, 8, rx);
        spi_bits(addr[15:8], 8, rx);
        spi_bits(addr[7:0], 8, rx);
        for (int b = 0; b < nbytes; b++) begin
            data = 8'($urandom_range(0, 255));
            nb = (cut_bits >= 0 && b == nbytes - 1) ? cut_bits : 8;
            spi_bits(data, nb, rx);
            if (kind == 1 && nb == 8) check_eq("rd_byte", rx, ref_mem[a]);
            if (kind == 2 && nb == 8 && wr_ok_m) begin
                exp_q.push_back({a, data});
                ref_mem[a] = data;
            end
            a = a + 1'b1;
        end
        tick(half);
        ss = 1'b1;
        if (cut_bits >= 0) begin
            tick(3);
            check_eq("abort_miso", miso, 0);
            check_eq("abort_active", active, 0);
        end
        tick(8);
`ifdef SPI_FRAM_TARGET_WREN_EN
        if (kind == 2) wel_m = 1'b0;
`endif
        if (kind == 1) begin
            check_eq("re_cnt", re_cnt - re0, nbytes + 1);
        end else begin
            check_eq("re_cnt", re_cnt - re0, 0);
            check_eq("miso_quiet", miso_hi - mh0, 0);
        end
        check_eq("we_cnt", obs_q.size() - obs0, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) check_eq("wr_addr_data", obs_q[obs_rd], e);
            else check_eq("wr_missing", 32'hFFFF_FFFF, e);
            obs_rd++;
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        logic [7:0]  rx;
        logic [7:0]  op;
        logic [15:0] addr;
        int          r;
        for (int i = 0; i < MEM_SZ; i++) begin
            ram[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = ram[i];
        end
        tick(4);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_re", mem_re, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        tick(4);

`ifdef SPI_FRAM_TARGET_WREN_EN
        run_txn(OP_WRITE, 16'h0000, 1, -1);
        run_txn(OP_WREN, 16'h0000, 0, -1);
        run_txn(OP_WRITE, 16'h0000, 1, -1);
        run_txn(OP_WRITE, 16'h0001, 1, -1);
        run_txn(OP_WREN, 16'h0000, 0, -1);
`endif
        run_txn(OP_WRITE, 16'h0010, 2, -1);

        ram[13'h1FFF] = 8'h5A; ref_mem[13'h1FFF] = 8'h5A;
        ram[13'h0000] = 8'hC3; ref_mem[13'h0000] = 8'hC3;
        run_txn(OP_READ, 16'h1FFF, 2, -1);

        run_txn(8'h9F, 16'($urandom_range(0, 65535)), 0, -1);

`ifdef SPI_FRAM_TARGET_WREN_EN
        run_txn(OP_WREN, 16'h0000, 0, -1);
`endif
        run_txn(OP_WRITE, 16'h0200, 1, 5);

        // Reset while the address is being shifted in.
        ss = 1'b0;
        tick(half);
        spi_bits(OP_WRITE, 8, rx);
        spi_bits(8'h12, 5, rx);
        reset = 1'b1;
        ss    = 1'b1;
        sck   = 1'b0;
        wel_m = 1'b0;
        tick(3);
        check_eq("midrst_miso", miso, 0);
        check_eq("midrst_we", mem_we, 0);
        check_eq("midrst_re", mem_re, 0);
        check_eq("midrst_active", active, 0);
        check_eq("midrst_addr", mem_addr, 0);
        check_eq("midrst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        tick(4);
        obs_rd = obs_q.size();
`ifdef SPI_FRAM_TARGET_WREN_EN
        run_txn(OP_WREN, 16'h0000, 0, -1);
`endif
        run_txn(OP_WRITE, 16'h0100, 1, -1);
        run_txn(OP_READ, 16'h0100, 1, -1);

        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) op = OP_READ;
            else if (r <= 6) op = OP_WRITE;
            else if (r == 7) op = OP_WREN;
            else if (r == 8) op = OP_WRDI;
            else op = 8'($urandom_range(0, 255));
            addr = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) addr[AW-1:0] = 13'h1FFE + 13'($urandom_range(0, 1));
            run_txn(op, addr, $urandom_range(1, 3), -1);
        end

        check_eq("we_re_exclusive", both_hi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
